// File: rtl/sysbus_mem_responder_if.sv
// ---------------------------------------------------------------------------
// sysbus_mem_responder_if
// Purpose : bundles the system-bus line-transfer signals exchanged between a
//           dcache-side initiator and the memory responder.
// Signals : bus_reqcyc  - initiator request / write-data valid
//           bus_req     - request address or write-beat data
//           bus_reqtag  - request tag {op, device[3:0], 8'h00}
//           bus_respack - initiator accepts the current read beat
//           bus_reqack  - responder accepted the request (1-cycle pulse)
//           bus_respcyc - read beat valid
//           bus_resp    - read beat data
//           bus_resptag - read response tag
// Modports: master (initiator side), slave (responder side)
// ---------------------------------------------------------------------------
interface sysbus_mem_responder_if #(
   parameter int DW = 64,
   parameter int TW = 13
);
   logic          bus_reqcyc;
   logic [DW-1:0] bus_req;
   logic [TW-1:0] bus_reqtag;
   logic          bus_respack;
   logic          bus_reqack;
   logic          bus_respcyc;
   logic [DW-1:0] bus_resp;
   logic [TW-1:0] bus_resptag;

   modport master (
      output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
   );

   modport slave (
      input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag
   );
endinterface

// File: rtl/sysbus_mem_responder.sv
// ---------------------------------------------------------------------------
// sysbus_mem_responder
// Purpose : memory-side end of the dcache line-transfer protocol. Accepts
//           64B line read/write requests addressed to the memory device,
//           acknowledges them, then streams (read) or absorbs (write) 8 beats
//           of 64 bits from/to an internal line array.
// Ports   : clk   - clock, all state on posedge
//           reset - asynchronous, active-low
//           bus   - sysbus_mem_responder_if.slave (request/response signals)
//           busy  - high whenever the responder is not idle
// Config  : SYSBUS_MEM_STALL_INJECT_EN - when defined, an 8-bit LFSR
//           (x^8+x^6+x^5+x^4+1, seed 8'hA5) randomly inserts one idle cycle
//           before each read beat and before the request acknowledge.
//           When undefined the timing is fixed and no LFSR exists.
// Notes   : the line array is not reset; all bus outputs are registered.
// ---------------------------------------------------------------------------
module sysbus_mem_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_LINES      = 256,
   parameter int RD_LATENCY     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   sysbus_mem_responder_if.slave    bus,
   output logic                     busy
);

   localparam int LIDX_W = $clog2(MEM_LINES);
   localparam int LAT_W  = $clog2(RD_LATENCY) + 1;
   localparam int WORDS  = MEM_LINES * 8;

   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic       SYSBUS_WRITE  = 1'b0;
   localparam logic [3:0] SYSBUS_MEMORY = 4'h1;
   localparam logic [BUS_TAG_WIDTH-1:0] RESP_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACK     = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_RD_BEAT = 3'd3,
      ST_WR_BEAT = 3'd4
   } state_e;

   state_e                    state_q, state_d;
   logic                      op_q, op_d;
   logic [LIDX_W-1:0]         line_q, line_d;
   logic [2:0]                beat_q, beat_d;
   logic [LAT_W-1:0]          lat_q, lat_d;
   logic                      pend_q, pend_d;   // acknowledge deferred by one cycle
   logic                      gap_q, gap_d;     // read beat deferred by one cycle
   logic                      reqack_q, reqack_d;
   logic                      respcyc_q, respcyc_d;
   logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
   logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;
   logic                      busy_q, busy_d;

   logic [BUS_DATA_WIDTH-1:0] mem_q [WORDS];
   logic                      mem_we_s;
   logic [LIDX_W+2:0]         mem_waddr_s;
   logic                      stall_s;
   logic                      req_hit_s;
   logic                      unused_tag_s;

   // Tag low byte carries no information for the responder.
   assign unused_tag_s = ^bus.bus_reqtag[7:0];

`ifdef SYSBUS_MEM_STALL_INJECT_EN
   logic [7:0] lfsr_q, lfsr_d;

   // LFSR next value: shift left, feedback taps for x^8+x^6+x^5+x^4+1.
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // LFSR register, free-running every clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Stall decision for the current cycle.
   always_comb begin
      stall_s = lfsr_q[0];
   end
`else
   // Stall injection disabled: never stall.
   always_comb begin
      stall_s = 1'b0;
   end
`endif

   // Request match: valid request addressed to the memory device.
   always_comb begin
      req_hit_s = bus.bus_reqcyc && (bus.bus_reqtag[11:8] == SYSBUS_MEMORY);
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      line_d      = line_q;
      beat_d      = beat_q;
      lat_d       = lat_q;
      pend_d      = pend_q;
      gap_d       = gap_q;
      reqack_d    = 1'b0;
      respcyc_d   = 1'b0;
      resp_d      = '0;
      resptag_d   = '0;
      mem_we_s    = 1'b0;
      mem_waddr_s = {line_q, beat_q};

      case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               pend_d   = 1'b0;
               state_d  = ST_ACK;
               reqack_d = 1'b1;
            end else if (req_hit_s) begin
               op_d   = bus.bus_reqtag[12];
               line_d = bus.bus_req[6 +: LIDX_W];
               if (stall_s) begin
                  pend_d = 1'b1;
               end else begin
                  state_d  = ST_ACK;
                  reqack_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ACK: begin
            if (op_q == SYSBUS_WRITE) begin
               state_d = ST_WR_BEAT;
               beat_d  = 3'd0;
            end else begin
               state_d = ST_RD_WAIT;
               lat_d   = '0;
            end
         end

         ST_RD_WAIT: begin
            if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
               state_d = ST_RD_BEAT;
               beat_d  = 3'd0;
               lat_d   = '0;
               if (stall_s) begin
                  gap_d = 1'b1;
               end else begin
                  respcyc_d = 1'b1;
                  resp_d    = mem_q[{line_q, 3'd0}];
                  resptag_d = RESP_TAG;
               end
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end

         ST_RD_BEAT: begin
            if (gap_q) begin
               // Deferred beat: beat_q already points at the beat to show.
               gap_d     = 1'b0;
               respcyc_d = 1'b1;
               resp_d    = mem_q[{line_q, beat_q}];
               resptag_d = RESP_TAG;
            end else if (beat_q == 3'd7) begin
               // Last beat is shown for one cycle only; no ack expected.
               state_d = ST_IDLE;
               beat_d  = 3'd0;
            end else if (bus.bus_respack) begin
               beat_d = beat_q + 3'd1;
               if (stall_s) begin
                  gap_d = 1'b1;
               end else begin
                  respcyc_d = 1'b1;
                  resp_d    = mem_q[{line_q, beat_q + 3'd1}];
                  resptag_d = RESP_TAG;
               end
            end else begin
               respcyc_d = 1'b1;
               resp_d    = resp_q;
               resptag_d = RESP_TAG;
            end
         end

         ST_WR_BEAT: begin
            if (bus.bus_reqcyc) begin
               mem_we_s = 1'b1;
               if (beat_q == 3'd7) begin
                  state_d = ST_IDLE;
                  beat_d  = 3'd0;
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end else begin
               beat_d = beat_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
            beat_d  = 3'd0;
            lat_d   = '0;
            pend_d  = 1'b0;
            gap_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // Control state and registered bus outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         op_q      <= 1'b0;
         line_q    <= '0;
         beat_q    <= 3'd0;
         lat_q     <= '0;
         pend_q    <= 1'b0;
         gap_q     <= 1'b0;
         reqack_q  <= 1'b0;
         respcyc_q <= 1'b0;
         resp_q    <= '0;
         resptag_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         line_q    <= line_d;
         beat_q    <= beat_d;
         lat_q     <= lat_d;
         pend_q    <= pend_d;
         gap_q     <= gap_d;
         reqack_q  <= reqack_d;
         respcyc_q <= respcyc_d;
         resp_q    <= resp_d;
         resptag_q <= resptag_d;
         busy_q    <= busy_d;
      end
   end

   // Line array write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= bus.bus_req;
      end
   end

   assign bus.bus_reqack  = reqack_q;
   assign bus.bus_respcyc = respcyc_q;
   assign bus.bus_resp    = resp_q;
   assign bus.bus_resptag = resptag_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sysbus_mem_responder
// Purpose : directed self-checking bench for sysbus_mem_responder. Drives the
//           initiator side of the interface and checks acks, read latency,
//           beat order/data/tag, stalls, device filtering, address aliasing
//           and behaviour across an asynchronous reset.
// ---------------------------------------------------------------------------
module tb_sysbus_mem_responder;

   localparam logic        RD       = 1'b1;
   localparam logic        WR       = 1'b0;
   localparam logic [3:0]  MEMDEV   = 4'h1;
   localparam logic [12:0] RESP_TAG = 13'h1100;

   logic clk;
   logic reset;
   logic busy;
   int   checks;
   int   failures;

   sysbus_mem_responder_if bus_if ();

   sysbus_mem_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit.
   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic op, input logic [63:0] addr);
      int n;
      bus_if.bus_reqcyc = 1'b1;
      bus_if.bus_req    = addr;
      bus_if.bus_reqtag = {op, MEMDEV, 8'h00};
      tick();
      n = 0;
      while (bus_if.bus_reqack !== 1'b1 && n < 4) begin
         tick();
         n++;
      end
      chk("reqack", 64'(bus_if.bus_reqack), 64'd1);
`ifndef SYSBUS_MEM_STALL_INJECT_EN
      chk("ack_latency", 64'(n), 64'd0);
`endif
      chk("busy_in_ack", 64'(busy), 64'd1);
      bus_if.bus_reqcyc = 1'b0;
      bus_if.bus_req    = 64'd0;
      bus_if.bus_reqtag = 13'd0;
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [7:0][63:0] d, input int gap_after);
      issue(WR, addr);
      tick();
      for (int b = 0; b < 8; b++) begin
         bus_if.bus_reqcyc = 1'b1;
         bus_if.bus_req    = d[b];
         tick();
         if (b == gap_after) begin
            bus_if.bus_reqcyc = 1'b0;
            bus_if.bus_req    = 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
            tick();
            chk("busy_in_gap", 64'(busy), 64'd1);
         end
      end
      bus_if.bus_reqcyc = 1'b0;
      bus_if.bus_req    = 64'd0;
      chk("busy_after_write", 64'(busy), 64'd0);
   endtask

   task automatic do_read(input logic [63:0] addr, input logic [7:0][63:0] d,
                          input int hold_beat, input int hold_n);
      int n;
      issue(RD, addr);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus_if.bus_respcyc !== 1'b1 && n < 12);
`ifndef SYSBUS_MEM_STALL_INJECT_EN
      chk("rd_latency", 64'(n), 64'd5);
`endif
      for (int b = 0; b < 8; b++) begin
         chk("rd_valid", 64'(bus_if.bus_respcyc), 64'd1);
         chk("rd_data", bus_if.bus_resp, d[b]);
         chk("rd_tag", 64'(bus_if.bus_resptag), 64'(RESP_TAG));
         if (b == hold_beat) begin
            for (int j = 0; j < hold_n; j++) begin
               tick();
               chk("hold_valid", 64'(bus_if.bus_respcyc), 64'd1);
               chk("hold_data", bus_if.bus_resp, d[b]);
            end
         end
         if (b < 7) begin
            bus_if.bus_respack = 1'b1;
            tick();
            bus_if.bus_respack = 1'b0;
`ifdef SYSBUS_MEM_STALL_INJECT_EN
            n = 0;
            while (bus_if.bus_respcyc !== 1'b1 && n < 3) begin
               tick();
               n++;
            end
`endif
         end else begin
            tick();
            chk("rd_end_valid", 64'(bus_if.bus_respcyc), 64'd0);
            chk("rd_end_tag", 64'(bus_if.bus_resptag), 64'd0);
            chk("rd_end_busy", 64'(busy), 64'd0);
         end
      end
   endtask

   logic [7:0][63:0] d1;
   logic [7:0][63:0] d2;
   logic [7:0][63:0] d3;
   int               n;

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      bus_if.bus_reqcyc  = 1'b0;
      bus_if.bus_req     = 64'd0;
      bus_if.bus_reqtag  = 13'd0;
      bus_if.bus_respack = 1'b0;

      d1 = {64'h8, 64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1};
      d2 = {64'hC0DE_0000_0000_0077, 64'hC0DE_0000_0000_0066,
            64'hC0DE_0000_0000_0055, 64'hC0DE_0000_0000_0044,
            64'hC0DE_0000_0000_0033, 64'hC0DE_0000_0000_0022,
            64'hC0DE_0000_0000_0011, 64'hC0DE_0000_0000_0000};

      // Reset state
      repeat (3) tick();
      chk("rst_reqack", 64'(bus_if.bus_reqack), 64'd0);
      chk("rst_respcyc", 64'(bus_if.bus_respcyc), 64'd0);
      chk("rst_resp", bus_if.bus_resp, 64'd0);
      chk("rst_resptag", 64'(bus_if.bus_resptag), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      tick();

      // Write line 0x40 with 1..8, read it straight back
      do_write(64'h40, d1, -1);
      do_read(64'h40, d1, -1, 0);

      // Withhold respack 5 cycles on beat 2
      do_read(64'h40, d1, 2, 5);

      // Request to another device is ignored
      bus_if.bus_reqcyc = 1'b1;
      bus_if.bus_req    = 64'h40;
      bus_if.bus_reqtag = {RD, 4'h3, 8'h00};
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("foreign_reqack", 64'(bus_if.bus_reqack), 64'd0);
         chk("foreign_busy", 64'(busy), 64'd0);
      end
      bus_if.bus_reqcyc = 1'b0;
      bus_if.bus_reqtag = 13'd0;
      tick();

      // Write with a gap after beat 3; read back via unaligned address
      do_write(64'h80, d2, 3);
      do_read(64'h87, d2, -1, 0);

      // Upper address bits alias onto line 1 (same as 0x40)
      do_read(64'hFFFF_0000_0000_4040, d1, -1, 0);

      // Reset in the middle of read beats
      issue(RD, 64'h80);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus_if.bus_respcyc !== 1'b1 && n < 12);
      for (int b = 0; b < 2; b++) begin
         bus_if.bus_respack = 1'b1;
         tick();
         bus_if.bus_respack = 1'b0;
         n = 0;
         while (bus_if.bus_respcyc !== 1'b1 && n < 3) begin
            tick();
            n++;
         end
      end
      chk("mid_read_data", bus_if.bus_resp, d2[2]);
      reset = 1'b0;
      tick();
      chk("midrst_reqack", 64'(bus_if.bus_reqack), 64'd0);
      chk("midrst_respcyc", 64'(bus_if.bus_respcyc), 64'd0);
      chk("midrst_resp", bus_if.bus_resp, 64'd0);
      chk("midrst_resptag", 64'(bus_if.bus_resptag), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      tick();
      do_read(64'h80, d2, -1, 0);

      // Reset during a write: beats already stored stay, rest keep old data
      do_write(64'hC0, d1, -1);
      issue(WR, 64'hC0);
      tick();
      for (int b = 0; b < 3; b++) begin
         bus_if.bus_reqcyc = 1'b1;
         bus_if.bus_req    = d2[b];
         tick();
      end
      bus_if.bus_reqcyc = 1'b0;
      reset = 1'b0;
      tick();
      chk("wrrst_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      tick();
      d3 = {64'h8, 64'h7, 64'h6, 64'h5, 64'h4,
            64'hC0DE_0000_0000_0022, 64'hC0DE_0000_0000_0011, 64'hC0DE_0000_0000_0000};
      do_read(64'hC0, d3, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
